// File: rtl/shift_add_mul4.sv
// Sequential 4x4 unsigned multiplier using shift-and-add, one iteration per RUN cycle.
// state | meaning: IDLE | waiting for start; RUN | four add/shift iterations; DONE | one-cycle result pulse
module shift_add_mul4 (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic       busy,
    output logic       done,
    output logic [7:0] product
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] mcand_q, mcand_d;
    logic [3:0] hi_q, hi_d;
    logic [3:0] lo_q, lo_d;
    logic [1:0] cnt_q, cnt_d;
    logic [7:0] product_q, product_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic [4:0] sum;

    always_comb begin
        state_d   = state_q;
        mcand_d   = mcand_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        cnt_d     = cnt_q;
        product_d = product_q;
        // Carry-out of the add lands in hi[3] directly after the right shift.
        sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, mcand_q} : 5'd0);

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    mcand_d = a;
                    lo_d    = b;
                    hi_d    = 4'd0;
                    cnt_d   = 2'd0;
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                hi_d  = sum[4:1];
                lo_d  = {sum[0], lo_q[3:1]};
                cnt_d = cnt_q + 2'd1;
                if (cnt_q == 2'd3) begin
                    state_d   = DONE;
                    product_d = {hi_d, lo_d};
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d == RUN);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            mcand_q   <= 4'd0;
            hi_q      <= 4'd0;
            lo_q      <= 4'd0;
            cnt_q     <= 2'd0;
            product_q <= 8'd0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            mcand_q   <= mcand_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            cnt_q     <= cnt_d;
            product_q <= product_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign product = product_q;

endmodule

// File: tb/tb_shift_add_mul4.sv
// Directed self-checking bench for shift_add_mul4 with a product scoreboard.
module tb_shift_add_mul4;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [3:0] a;
    logic [3:0] b;
    logic       busy;
    logic       done;
    logic [7:0] product;

    int         errors = 0;
    int         checks = 0;
    int         cyc = 0;
    int         last_done = 0;
    bit         check_gap = 1'b0;
    logic [7:0] sb_q[$];

    shift_add_mul4 dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .a       (a),
        .b       (b),
        .busy    (busy),
        .done    (done),
        .product (product)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock, sample 1 time unit later and score any done pulse.
    task automatic step();
        logic [7:0] e;
        @(posedge clk);
        #1;
        cyc++;
        chk("busy_done_exclusive", {31'd0, busy & done}, 32'd0);
        if (done === 1'b1) begin
            chk("sb_nonempty", {31'd0, sb_q.size() != 0}, 32'd1);
            if (sb_q.size() != 0) begin
                e = sb_q.pop_front();
                chk("done_product", {24'd0, product}, {24'd0, e});
            end
            if (check_gap)
                chk("done_gap", cyc - last_done, 32'd5);
            last_done = cyc;
        end
    endtask

    function automatic logic [7:0] mul(input logic [3:0] x, input logic [3:0] y);
        logic [7:0] xe, ye;
        xe = {4'd0, x};
        ye = {4'd0, y};
        return xe * ye;
    endfunction

    task automatic run_op(input logic [3:0] oa, input logic [3:0] ob);
        start = 1'b1;
        a = oa;
        b = ob;
        sb_q.push_back(mul(oa, ob));
        step();
        start = 1'b0;
        chk("busy_run1", {31'd0, busy}, 32'd1);
        chk("done_run1", {31'd0, done}, 32'd0);
        for (int k = 0; k < 3; k++) begin
            a = 4'($urandom);
            b = 4'($urandom);
            step();
            chk("busy_run", {31'd0, busy}, 32'd1);
            chk("done_run", {31'd0, done}, 32'd0);
        end
        step();
        chk("done_latency", {31'd0, done}, 32'd1);
        chk("busy_in_done", {31'd0, busy}, 32'd0);
        step();
        chk("done_single", {31'd0, done}, 32'd0);
        chk("product_hold", {24'd0, product}, {24'd0, mul(oa, ob)});
        chk("busy_idle", {31'd0, busy}, 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        a = 4'd0;
        b = 4'd0;
        step();
        start = 1'b1;
        a = 4'd3;
        b = 4'd5;
        step();
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_done", {31'd0, done}, 32'd0);
        chk("reset_product", {24'd0, product}, 32'd0);
        start = 1'b0;
        rst = 1'b0;

        run_op(4'd3, 4'd5);
        run_op(4'd15, 4'd15);
        run_op(4'd0, 4'd9);

        // Start held high through RUN is ignored; the start seen in DONE is taken.
        start = 1'b1;
        a = 4'd9;
        b = 4'd7;
        sb_q.push_back(8'h3F);
        step();
        a = 4'd2;
        b = 4'd2;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("ignore_busy", {31'd0, busy}, 32'd1);
        end
        sb_q.push_back(8'h04);
        step();
        chk("ignore_first_done", {31'd0, done}, 32'd1);
        check_gap = 1'b1;
        step();
        start = 1'b0;
        chk("b2b_busy", {31'd0, busy}, 32'd1);
        for (int k = 0; k < 3; k++) step();
        step();
        chk("b2b_second_done", {31'd0, done}, 32'd1);
        check_gap = 1'b0;
        step();

        // Reset during the second RUN cycle aborts with no done.
        start = 1'b1;
        a = 4'd12;
        b = 4'd11;
        step();
        start = 1'b0;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_done", {31'd0, done}, 32'd0);
        chk("abort_product", {24'd0, product}, 32'd0);
        for (int k = 0; k < 5; k++) begin
            step();
            chk("abort_no_done", {31'd0, done}, 32'd0);
        end
        run_op(4'd12, 4'd11);

        // All operand pairs back-to-back with start held high.
        for (int i = 0; i < 256; i++) begin
            logic [7:0] iv;
            iv = 8'(i);
            check_gap = (i > 0);
            start = 1'b1;
            a = iv[7:4];
            b = iv[3:0];
            sb_q.push_back(mul(iv[7:4], iv[3:0]));
            step();
            chk("exh_busy", {31'd0, busy}, 32'd1);
            for (int k = 0; k < 3; k++) step();
            step();
            chk("exh_done", {31'd0, done}, 32'd1);
        end
        start = 1'b0;
        check_gap = 1'b0;
        step();
        chk("exh_idle", {31'd0, busy | done}, 32'd0);
        chk("sb_drained", sb_q.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
